// File: rtl/race_start_scheduler_if.sv
// Race start scheduler bus: lane requests and light status in,
// grant, start pulse, fault flags and race count out.
interface race_start_scheduler_if #(
  parameter int NUM_LANES = 4,
  parameter int CNT_W     = 8
);
  logic [NUM_LANES-1:0] Req;
  logic [NUM_LANES-1:0] Launch;
  logic                 Red;
  logic                 Yellow;
  logic                 Green;
  logic                 Start;
  logic [NUM_LANES-1:0] Grant;
  logic [NUM_LANES-1:0] Fault;
  logic                 Busy;
  logic [CNT_W-1:0]     Race_Count;

  modport master (
    input  Req, Launch, Red, Yellow, Green,
    output Start, Grant, Fault, Busy, Race_Count
  );

  modport slave (
    output Req, Launch, Red, Yellow, Green,
    input  Start, Grant, Fault, Busy, Race_Count
  );
endinterface

// File: rtl/race_start_scheduler.sv
// Round-robin lane scheduler in front of a shared race light controller.
// Detects false starts, enforces a cooldown and counts clean races.
module race_start_scheduler #(
  parameter int NUM_LANES   = 4,
  parameter int GO_TIMEOUT  = 8,
  parameter int LOCKOUT_SEC = 2,
  parameter int CNT_W       = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  race_start_scheduler_if.master bus
);

  localparam int PW   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int TMAX = (GO_TIMEOUT > LOCKOUT_SEC) ?
                        GO_TIMEOUT : LOCKOUT_SEC;
  localparam int TW   = $clog2(TMAX + 2);

  localparam logic [TW-1:0] GO_LAST = TW'(GO_TIMEOUT - 1);
  localparam logic [TW-1:0] CD_LAST =
    (LOCKOUT_SEC > 0) ? TW'(LOCKOUT_SEC - 1) : '0;
  localparam logic [PW-1:0] LAST_LANE = PW'(NUM_LANES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARM      = 3'd1,
    S_WAIT_GO  = 3'd2,
    S_RACE     = 3'd3,
    S_ABORT    = 3'd4,
    S_COOLDOWN = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_LANES-1:0] grant_q, grant_d;
  logic [NUM_LANES-1:0] fault_q, fault_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 seen_q, seen_d;

  logic                 start;
  logic                 busy;
  logic                 pick_vld;
  logic [PW-1:0]        pick_idx;
  logic [NUM_LANES-1:0] pick_oh;
  logic                 launch_hit;
  logic                 unused_lamps;

  // Red/Yellow carry no decision weight; only Green edges matter.
  assign unused_lamps = bus.Red | bus.Yellow;

  always_comb begin
    int            j;
    logic [PW-1:0] jj;
    pick_vld = 1'b0;
    pick_idx = '0;
    j        = 0;
    jj       = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NUM_LANES) j = j - NUM_LANES;
      jj = PW'(j);
      if (!pick_vld && bus.Req[jj]) begin
        pick_vld = 1'b1;
        pick_idx = jj;
      end
    end
  end

  assign pick_oh    = NUM_LANES'(1) << pick_idx;
  assign launch_hit = |(bus.Launch & grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    fault_d = fault_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    count_d = count_q;
    seen_d  = seen_q;
    start   = 1'b0;
    busy    = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (pick_vld) begin
          grant_d = pick_oh;
          fault_d = fault_q & ~pick_oh;
          ptr_d   = (pick_idx == LAST_LANE) ?
                    '0 : pick_idx + 1'b1;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        start   = 1'b1;
        timer_d = '0;
        seen_d  = 1'b0;
        state_d = S_WAIT_GO;
      end
      S_WAIT_GO: begin
        timer_d = timer_q + 1'b1;
        if (bus.Green) begin
          state_d = S_RACE;
        end else if (launch_hit) begin
          fault_d = fault_q | grant_q;
          state_d = S_ABORT;
        end else if (timer_q >= GO_LAST) begin
          timer_d = '0;
          state_d = S_COOLDOWN;
        end
      end
      S_RACE: begin
        if (!bus.Green) begin
          count_d = count_q + 1'b1;
          timer_d = '0;
          state_d = S_COOLDOWN;
        end
      end
      S_ABORT: begin
        // Ride out the light sequence: full Green pulse or no Green at all.
        if (bus.Green) begin
          seen_d = 1'b1;
        end else if (seen_q || timer_q >= GO_LAST) begin
          timer_d = '0;
          state_d = S_COOLDOWN;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_COOLDOWN: begin
        if (timer_q >= CD_LAST) begin
          grant_d = '0;
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        grant_d = '0;
        timer_d = '0;
        seen_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(negedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      fault_q <= '0;
      ptr_q   <= '0;
      timer_q <= '0;
      count_q <= '0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      fault_q <= fault_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
      count_q <= count_d;
      seen_q  <= seen_d;
    end
  end

  assign bus.Start      = start;
  assign bus.Busy       = busy;
  assign bus.Grant      = grant_q;
  assign bus.Fault      = fault_q;
  assign bus.Race_Count = count_q;

endmodule

// File: tb/tb_race_start_scheduler.sv
// Scoreboarded bench for race_start_scheduler with a light-controller
// model and a race-level reference model.
module tb_race_start_scheduler;

  localparam int N    = 4;
  localparam int GO   = 8;
  localparam int LOCK = 2;
  localparam int CD   = (LOCK > 0) ? LOCK : 1;

  typedef struct {
    logic [3:0] grant;
    logic [3:0] fault;
    logic [7:0] count;
    int         span;
  } exp_t;

  logic Clk;
  logic Reset;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  exp_t q[$];

  int         m_ptr;
  logic [3:0] m_fault;
  logic [7:0] m_count;

  race_start_scheduler_if #(.NUM_LANES(N), .CNT_W(8)) bus ();

  race_start_scheduler #(
    .NUM_LANES(N), .GO_TIMEOUT(GO),
    .LOCKOUT_SEC(LOCK), .CNT_W(8)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic abort_sim(input string name);
    errors++;
    checks++;
    $display("FAIL %s: bound expired", name);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $fatal(1);
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_fault = '0;
    m_count = '0;
  endtask

  task automatic idle_inputs();
    bus.Req    = '0;
    bus.Launch = '0;
    bus.Green  = 1'b0;
    bus.Yellow = 1'b0;
    bus.Red    = 1'b1;
  endtask

  task automatic reset_all();
    idle_inputs();
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    Reset = 1'b0;
    model_reset();
  endtask

  // d: cycles from Start to Green (>GO means never), l: Green length,
  // f: cycle the granted lane launches (0 = never).
  task automatic run_race(input logic [3:0] pat, input int d,
                          input int l, input int f, input bit noise);
    logic [3:0] oh;
    int         lane;
    int         k;
    int         w;
    int         t;
    bit         green_ok;
    bit         is_fault;
    exp_t       e;
    lane = -1;
    for (int i = 0; i < N; i++) begin
      k = (m_ptr + i) % N;
      if (lane < 0 && pat[k]) lane = k;
    end
    oh       = 4'b0001 << lane;
    m_ptr    = (lane + 1) % N;
    m_fault  = m_fault & ~oh;
    green_ok = (d <= GO);
    is_fault = (f >= 1) && (f < (green_ok ? d : GO));
    if (is_fault) m_fault = m_fault | oh;
    if (green_ok && !is_fault) m_count = m_count + 8'd1;
    e.grant = oh;
    e.fault = m_fault;
    e.count = m_count;
    e.span  = (green_ok ? d + l + 1 : GO + 1) + CD;
    q.push_back(e);

    bus.Req = pat;
    w = 0;
    while (w < 4) begin
      @(posedge Clk);
      w++;
      if (bus.Start) break;
    end
    check("req_to_start", w, 1);
    if (!bus.Start) abort_sim("start_timeout");
    bus.Req    = noise ? 4'($urandom) : 4'b0;
    bus.Launch = noise ? (4'($urandom) & ~oh) : 4'b0;
    for (t = 1; t <= 80; t++) begin
      @(posedge Clk);
      if (bus.Grant == 4'b0) break;
      bus.Green  = green_ok && t >= d && t < d + l;
      bus.Yellow = green_ok && t >= d - 2 && t < d;
      bus.Red    = !bus.Green && !bus.Yellow;
      bus.Launch = noise ? (4'($urandom) & ~oh) : 4'b0;
      if (t == f) bus.Launch = bus.Launch | oh;
      bus.Req    = noise ? 4'($urandom) : 4'b0;
    end
    if (t > 80) abort_sim("race_end_timeout");
    idle_inputs();
  endtask

  initial begin
    int         cyc;
    int         start_t;
    int         starts;
    logic [3:0] prev_g;
    exp_t       e;
    cyc     = 0;
    start_t = 0;
    starts  = 0;
    prev_g  = '0;
    forever begin
      @(posedge Clk);
      cyc++;
      if (!mon_en) begin
        starts = 0;
      end else begin
        if (bus.Start) begin
          starts++;
          start_t = cyc;
          check("start_with_grant", 32'(bus.Grant != 0), 1);
        end
        if (prev_g != 0 && bus.Grant != 0)
          check("grant_hold", bus.Grant, prev_g);
        if (prev_g != 0 && bus.Grant == 0) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL race_end: got race end expected none");
          end else begin
            e = q.pop_front();
            check("grant", prev_g, e.grant);
            check("fault", bus.Fault, e.fault);
            check("race_count", bus.Race_Count, e.count);
            check("race_span", cyc - start_t, e.span);
            check("start_pulses", starts, 1);
            check("busy_idle", bus.Busy, 0);
          end
          starts = 0;
        end
      end
      prev_g = bus.Grant;
    end
  end

  initial begin
    int         w;
    int         d;
    int         f;
    bit         green;
    logic [3:0] pat;
    idle_inputs();
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    check("rst_start", bus.Start, 0);
    check("rst_grant", bus.Grant, 0);
    check("rst_fault", bus.Fault, 0);
    check("rst_busy", bus.Busy, 0);
    check("rst_count", bus.Race_Count, 0);
    Reset = 1'b0;
    model_reset();
    mon_en = 1'b1;

    run_race(4'b0010, 5, 6, 0, 1'b0);
    reset_all();
    repeat (5) run_race(4'b1111, 3, 2, 0, 1'b1);
    run_race(4'b0100, 5, 3, 3, 1'b1);
    run_race(4'b0001, 4, 2, 2, 1'b1);
    run_race(4'b0100, 4, 2, 0, 1'b1);
    run_race(4'b1000, 99, 1, 0, 1'b1);
    run_race(4'b1000, 99, 1, 3, 1'b1);
    run_race(4'b0010, 4, 3, 4, 1'b1);
    run_race(4'b0001, 2, 2, 0, 1'b1);
    run_race(4'b0001, 2, 2, 0, 1'b1);

    // Reset in the middle of a race with Green still up.
    mon_en  = 1'b0;
    bus.Req = 4'b0001;
    w = 0;
    while (w < 4) begin
      @(posedge Clk);
      w++;
      if (bus.Start) break;
    end
    check("mid_rst_start", bus.Start, 1);
    bus.Req = '0;
    for (int t = 1; t <= 6; t++) begin
      @(posedge Clk);
      bus.Green = (t >= 2);
    end
    check("mid_rst_pre_grant", bus.Grant, 4'b0001);
    Reset = 1'b1;
    @(posedge Clk);
    check("mid_rst_grant", bus.Grant, 0);
    check("mid_rst_busy", bus.Busy, 0);
    check("mid_rst_count", bus.Race_Count, 0);
    check("mid_rst_fault", bus.Fault, 0);
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    bus.Green = 1'b0;
    repeat (4) @(posedge Clk);
    check("post_rst_count", bus.Race_Count, 0);
    check("post_rst_busy", bus.Busy, 0);
    model_reset();
    q.delete();
    mon_en = 1'b1;

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) @(posedge Clk);
      pat   = 4'($urandom_range(1, 15));
      green = ($urandom_range(0, 4) != 0);
      d     = green ? $urandom_range(1, GO) : 99;
      f     = 0;
      if ($urandom_range(0, 2) == 1)
        f = green ? $urandom_range(1, d + 2) :
                    $urandom_range(1, GO - 1);
      run_race(pat, d, $urandom_range(1, 6), f, 1'b1);
    end

    for (int r = 0; r < 260; r++)
      run_race(4'($urandom_range(1, 15)), 1, 1, 0, 1'b1);

    repeat (3) @(posedge Clk);
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
